// File: rtl/sram_raster_reader_if.sv
// SRAM read port plus the coordinate-tagged pixel stream driven by the raster reader.
// Widths must match the reader's IMG_W/IMG_H (X_W = clog2(IMG_W), Y_W = clog2(IMG_H), minimum 1).
interface sram_raster_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int X_W    = 8,
  parameter int Y_W    = 8
);
  logic              sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_q;
  logic              pix_valid;
  logic              pix_ready;
  logic [DATA_W-1:0] pix_data;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_eol;
  logic              pix_last;

  modport master (
    output sram_wen, sram_addr,
    input  sram_q,
    output pix_valid,
    input  pix_ready,
    output pix_data, pix_x, pix_y, pix_eol, pix_last
  );

  modport slave (
    input  sram_wen, sram_addr,
    output sram_q,
    input  pix_valid,
    output pix_ready,
    input  pix_data, pix_x, pix_y, pix_eol, pix_last
  );
endinterface

// File: rtl/sram_raster_reader.sv
// Raster-order frame fetch from a 1-cycle sync-read pixel SRAM, streamed out through a
// 2-entry FIFO that absorbs the read latency and downstream backpressure.
module sram_raster_reader #(
  parameter int                ADDR_W    = 16,
  parameter int                DATA_W    = 8,
  parameter int                IMG_W     = 256,
  parameter int                IMG_H     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  sram_raster_reader_if.master bus
);
  localparam int X_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t            state_q, state_d;
  logic              start_acc, issue, room, last_issue;
  logic              push, pop, frame_end;
  logic              done_q;

  logic [ADDR_W-1:0] addr_p0;
  logic [X_W-1:0]    x_p0;
  logic [Y_W-1:0]    y_p0;

  logic              vld_p1;
  logic [X_W-1:0]    x_p1;
  logic [Y_W-1:0]    y_p1;

  logic [1:0]        count_q;
  logic              wr_ptr_q, rd_ptr_q;
  logic [DATA_W-1:0] data_mem [2];
  logic [X_W-1:0]    x_mem    [2];
  logic [Y_W-1:0]    y_mem    [2];
  logic              head_vld, head_eol, head_last;

  assign head_vld  = (count_q != 2'd0);
  assign head_eol  = (x_mem[rd_ptr_q] == X_LAST);
  assign head_last = head_eol && (y_mem[rd_ptr_q] == Y_LAST);

  assign pop  = head_vld && bus.pix_ready;
  assign push = vld_p1;

  // Entries already held plus the read coming back must leave a free slot after this cycle's pop.
  assign room       = ({1'b0, count_q} + {2'b00, vld_p1}) < (3'd2 + {2'b00, pop});
  assign last_issue = (x_p0 == X_LAST) && (y_p0 == Y_LAST);

  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    issue     = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = READ;
        end
      end
      READ: begin
        if (room) begin
          issue = 1'b1;
          if (last_issue) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head_last) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: address/coordinate generation; sram_addr always shows the next read to issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      addr_p0 <= BASE_ADDR;
      x_p0    <= '0;
      y_p0    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= frame_end;
      if (start_acc) begin
        addr_p0 <= BASE_ADDR;
        x_p0    <= '0;
        y_p0    <= '0;
      end else if (issue) begin
        addr_p0 <= addr_p0 + ADDR_W'(1);
        if (x_p0 == X_LAST) begin
          x_p0 <= '0;
          y_p0 <= (y_p0 == Y_LAST) ? '0 : y_p0 + Y_W'(1);
        end else begin
          x_p0 <= x_p0 + X_W'(1);
        end
      end
    end
  end

  // Stage p1: read in flight; its data arrives on sram_q this cycle and is pushed at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      vld_p1  <= issue;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      x_p1 <= x_p0;
      y_p1 <= y_p0;
    end
    if (push) begin
      data_mem[wr_ptr_q] <= bus.sram_q;
      x_mem[wr_ptr_q]    <= x_p1;
      y_mem[wr_ptr_q]    <= y_p1;
    end
  end

  // Output stage: FIFO head drives the stream; the head slot is never written while occupied.
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = addr_p0;
  assign bus.pix_valid = head_vld;
  assign bus.pix_data  = data_mem[rd_ptr_q];
  assign bus.pix_x     = x_mem[rd_ptr_q];
  assign bus.pix_y     = y_mem[rd_ptr_q];
  assign bus.pix_eol   = head_eol;
  assign bus.pix_last  = head_last;

  assign busy = (state_q != IDLE);
  assign done = done_q;
endmodule

// File: tb/tb_sram_raster_reader.sv
// Bench for sram_raster_reader: three instances (4x4 @0x0010, 2x2 @0xFFFE, 32x16 @0x1234)
// sharing one behavioural SRAM, each checked against a frame-level expected-pixel queue.
module tb_sram_raster_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start0, start1, start2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;

  sram_raster_reader_if #(.ADDR_W(16), .DATA_W(8), .X_W(2), .Y_W(2)) b0 ();
  sram_raster_reader_if #(.ADDR_W(16), .DATA_W(8), .X_W(1), .Y_W(1)) b1 ();
  sram_raster_reader_if #(.ADDR_W(16), .DATA_W(8), .X_W(5), .Y_W(4)) b2 ();

  sram_raster_reader #(.ADDR_W(16), .DATA_W(8), .IMG_W(4), .IMG_H(4), .BASE_ADDR(16'h0010)) u0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0), .bus(b0));
  sram_raster_reader #(.ADDR_W(16), .DATA_W(8), .IMG_W(2), .IMG_H(2), .BASE_ADDR(16'hFFFE)) u1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .bus(b1));
  sram_raster_reader #(.ADDR_W(16), .DATA_W(8), .IMG_W(32), .IMG_H(16), .BASE_ADDR(16'h1234)) u2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .bus(b2));

  logic [7:0] mem [0:65535];
  always @(posedge clk) b0.sram_q <= mem[b0.sram_addr];
  always @(posedge clk) b1.sram_q <= mem[b1.sram_addr];
  always @(posedge clk) b2.sram_q <= mem[b2.sram_addr];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt0 = 0, done_cnt1 = 0, done_cnt2 = 0;
  int xfer0 = 0, xfer2 = 0, first2 = 0, last2 = 0;
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pk(input logic [7:0] d, input int x, input int y,
                                     input bit e, input bit l);
    return {d, x[7:0], y[7:0], 6'd0, e, l};
  endfunction

  // Reference: pixel k of a frame is mem[(base + k) mod 2^16] at x = k mod w, y = k div w.
  task automatic push_frame(input int which, input int base, input int w, input int h);
    logic [31:0] e;
    int a;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++) begin
        a = (base + y * w + x) % 65536;
        e = pk(mem[a], x, y, x == w - 1, (x == w - 1) && (y == h - 1));
        case (which)
          0: q0.push_back(e);
          1: q1.push_back(e);
          default: q2.push_back(e);
        endcase
      end
  endtask

  function automatic int dcnt(input int which);
    case (which)
      0: return done_cnt0;
      1: return done_cnt1;
      default: return done_cnt2;
    endcase
  endfunction

  task automatic set_ready(input int which, input logic v);
    case (which)
      0: b0.pix_ready = v;
      1: b1.pix_ready = v;
      default: b2.pix_ready = v;
    endcase
  endtask

  task automatic pulse_start(input int which);
    @(posedge clk); #1;
    case (which)
      0: start0 = 1'b1;
      1: start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int dc, input bit rnd, input int budget);
    int n = 0;
    while (dcnt(which) == dc && n < budget) begin
      if (rnd) set_ready(which, 1'($urandom_range(0, 1)));
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (dcnt(which) == dc) begin
      bad++;
      $display("FAIL wait_done%0d: no done within %0d cycles", which, budget);
    end
    set_ready(which, 1'b1);
  endtask

  // Instance 0 monitor: scoreboard, stall stability, read-ahead bound, done count.
  initial begin
    logic [31:0] got, prevp, e;
    logic [15:0] d;
    bit stall;
    int acc, outst;
    stall = 0; acc = 0; prevp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 0;
        acc   = 0;
      end else begin
        got = pk(b0.pix_data, int'(b0.pix_x), int'(b0.pix_y), b0.pix_eol, b0.pix_last);
        if (busy0) begin
          d     = b0.sram_addr - 16'h0010;
          outst = int'(d) - acc;
          chk("ahead0", {31'd0, (outst >= 0 && outst <= 2)}, 32'd1);
        end
        if (stall) begin
          chk("stall0_vld", {31'd0, b0.pix_valid}, 32'd1);
          chk("stall0_pix", got, prevp);
        end
        if (b0.pix_valid && b0.pix_ready) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL pix0: unexpected transfer got %0h", got);
          end else begin
            e = q0.pop_front();
            chk("pix0", got, e);
            if (e[0]) acc = -1;
          end
          acc++;
          xfer0++;
        end
        stall = b0.pix_valid && !b0.pix_ready;
        prevp = got;
        if (done0) done_cnt0++;
      end
    end
  end

  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got = pk(b1.pix_data, int'(b1.pix_x), int'(b1.pix_y), b1.pix_eol, b1.pix_last);
        if (b1.pix_valid && b1.pix_ready) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL pix1: unexpected transfer got %0h", got);
          end else chk("pix1", got, q1.pop_front());
        end
        if (done1) done_cnt1++;
      end
    end
  end

  initial begin
    logic [31:0] got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        got = pk(b2.pix_data, int'(b2.pix_x), int'(b2.pix_y), b2.pix_eol, b2.pix_last);
        if (b2.pix_valid && b2.pix_ready) begin
          if (q2.size() == 0) begin
            total++; bad++;
            $display("FAIL pix2: unexpected transfer got %0h", got);
          end else chk("pix2", got, q2.pop_front());
          if (xfer2 == 0) first2 = cyc;
          last2 = cyc;
          xfer2++;
        end
        if (done2) done_cnt2++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         start;
    bit         ready;
    bit         vld;
    logic [7:0] data;
    int         x;
    int         y;
    bit         eol;
    bit         last;
    bit         done;
    bit         busy;
  } vec_t;

  initial begin
    vec_t tv [21];
    logic [15:0] ea [4];
    int dc, n, x0, k;

    for (int c = 0; c < 21; c++) begin
      k = c - 3;
      tv[c].start = (c == 0);
      tv[c].ready = 1'b1;
      tv[c].vld   = (k >= 0 && k < 16);
      tv[c].data  = 8'(k);
      tv[c].x     = k % 4;
      tv[c].y     = k / 4;
      tv[c].eol   = (k >= 0) && (k % 4 == 3);
      tv[c].last  = (k == 15);
      tv[c].done  = (c == 19);
      tv[c].busy  = (c >= 1 && c <= 18);
    end
    ea[0] = 16'hFFFE; ea[1] = 16'hFFFF; ea[2] = 16'h0000; ea[3] = 16'h0001;

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    b0.pix_ready = 1'b1; b1.pix_ready = 1'b1; b2.pix_ready = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) mem[16 + i] = 8'(i);
    mem[16'hFFFD] = 8'h5A; mem[16'hFFFE] = 8'hA1; mem[16'hFFFF] = 8'hB2;
    mem[16'h0000] = 8'hC3; mem[16'h0001] = 8'hD4; mem[16'h0002] = 8'h6B;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_done0", {31'd0, done0}, 32'd0);
    chk("rst_vld0", {31'd0, b0.pix_valid}, 32'd0);
    chk("rst_wen0", {31'd0, b0.sram_wen}, 32'd1);
    chk("rst_addr0", {16'd0, b0.sram_addr}, 32'h0010);
    chk("rst_addr1", {16'd0, b1.sram_addr}, 32'hFFFE);
    chk("rst_addr2", {16'd0, b2.sram_addr}, 32'h1234);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Cycle-exact 4x4 frame from the vector table.
    dc = done_cnt0;
    push_frame(0, 16'h0010, 4, 4);
    for (int c = 0; c < 21; c++) begin
      @(posedge clk); #1;
      start0 = tv[c].start;
      b0.pix_ready = tv[c].ready;
      @(negedge clk);
      chk("t1_vld", {31'd0, b0.pix_valid}, {31'd0, tv[c].vld});
      chk("t1_busy", {31'd0, busy0}, {31'd0, tv[c].busy});
      chk("t1_done", {31'd0, done0}, {31'd0, tv[c].done});
      if (tv[c].vld)
        chk("t1_pix", pk(b0.pix_data, int'(b0.pix_x), int'(b0.pix_y), b0.pix_eol, b0.pix_last),
            pk(tv[c].data, tv[c].x, tv[c].y, tv[c].eol, tv[c].last));
    end
    chk("t1_ndone", done_cnt0 - dc, 1);
    chk("t1_empty", q0.size(), 0);

    // Random 50% backpressure, several frames.
    for (int f = 0; f < 4; f++) begin
      dc = done_cnt0;
      push_frame(0, 16'h0010, 4, 4);
      pulse_start(0);
      wait_done(0, dc, 1'b1, 300);
      chk("t3_ndone", done_cnt0 - dc, 1);
      chk("t3_empty", q0.size(), 0);
    end

    // Start re-pulsed mid-frame is ignored.
    dc = done_cnt0;
    push_frame(0, 16'h0010, 4, 4);
    pulse_start(0);
    repeat (5) @(posedge clk);
    #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    wait_done(0, dc, 1'b0, 100);
    repeat (4) @(posedge clk);
    chk("t4_single_done", done_cnt0 - dc, 1);
    chk("t4_empty", q0.size(), 0);
    chk("t4_idle", {31'd0, busy0}, 32'd0);

    // Start accepted in the done cycle: second frame valid three cycles later.
    dc = done_cnt0;
    push_frame(0, 16'h0010, 4, 4);
    pulse_start(0);
    for (n = 0; n < 100 && !done0; n++) begin
      @(posedge clk); #1;
    end
    total++;
    if (!done0) begin
      bad++;
      $display("FAIL t4_done_wait: done not seen within 100 cycles");
    end else begin
      start0 = 1'b1;
      push_frame(0, 16'h0010, 4, 4);
      @(posedge clk); #1 start0 = 1'b0;
      @(negedge clk);
      chk("t4_c1_vld", {31'd0, b0.pix_valid}, 32'd0);
      chk("t4_c1_busy", {31'd0, busy0}, 32'd1);
      @(negedge clk);
      chk("t4_c2_vld", {31'd0, b0.pix_valid}, 32'd0);
      @(negedge clk);
      chk("t4_c3_vld", {31'd0, b0.pix_valid}, 32'd1);
      wait_done(0, dc + 1, 1'b0, 100);
      chk("t4_two_frames", done_cnt0 - dc, 2);
    end

    // Reset after five transfers discards the frame, no done, then a clean frame.
    @(posedge clk); #1;
    dc = done_cnt0;
    push_frame(0, 16'h0010, 4, 4);
    x0 = xfer0;
    pulse_start(0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t5_xfers", xfer0 - x0, 5);
    chk("t5_vld", {31'd0, b0.pix_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy0}, 32'd0);
    chk("t5_done", {31'd0, done0}, 32'd0);
    chk("t5_addr", {16'd0, b0.sram_addr}, 32'h0010);
    chk("t5_wen", {31'd0, b0.sram_wen}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    q0.delete();
    repeat (6) @(posedge clk);
    chk("t5_no_done", done_cnt0 - dc, 0);
    push_frame(0, 16'h0010, 4, 4);
    pulse_start(0);
    wait_done(0, dc, 1'b0, 100);
    chk("t5_fresh_done", done_cnt0 - dc, 1);
    chk("t5_empty", q0.size(), 0);

    // 2x2 frame whose addresses wrap through 0xFFFF.
    dc = done_cnt1;
    push_frame(1, 16'hFFFE, 2, 2);
    pulse_start(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_addr", {16'd0, b1.sram_addr}, {16'd0, ea[i]});
    end
    wait_done(1, dc, 1'b0, 50);
    chk("t6_ndone", done_cnt1 - dc, 1);
    chk("t6_empty", q1.size(), 0);

    // 32x16 random image at full rate, then under random backpressure.
    dc = done_cnt2;
    xfer2 = 0;
    push_frame(2, 16'h1234, 32, 16);
    pulse_start(2);
    wait_done(2, dc, 1'b0, 1000);
    chk("t2_xfers", xfer2, 512);
    chk("t2_span", last2 - first2 + 1, 512);
    chk("t2_idle", {31'd0, busy2}, 32'd0);
    chk("t2_empty", q2.size(), 0);
    dc = done_cnt2;
    xfer2 = 0;
    push_frame(2, 16'h1234, 32, 16);
    pulse_start(2);
    wait_done(2, dc, 1'b1, 3000);
    chk("t2r_xfers", xfer2, 512);
    chk("t2r_empty", q2.size(), 0);
    chk("t2r_ndone", done_cnt2 - dc, 1);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
